// File: rtl/rv32m_pkg.sv
// Shared constants for the RV32M multiply/divide unit: funct3 codes, FSM states, width.
package rv32m_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCalc  = 2'd1,
        StFinal = 2'd2
    } state_e;

endpackage

// File: rtl/rv32m_sign_fix.sv
// Combinational conditional two's-complement negate, used for operand magnitudes
// and for the final result sign correction.
module rv32m_sign_fix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] data_in,
    input  logic         neg,
    output logic [W-1:0] data_out
);

    assign data_out = neg ? (~data_in + W'(1)) : data_in;

endmodule

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per clock, one op in flight.
// Shift-add multiply on magnitudes, restoring divide, sign fix applied in the final state.
module rv32m_muldiv_unit #(
    parameter int unsigned XLEN  = rv32m_pkg::XLEN,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);
    import rv32m_pkg::*;

    if (XLEN != 32 || (64'd1 << CNT_W) <= 64'(XLEN)) begin : g_param_chk
        $error("rv32m_muldiv_unit: XLEN must be 32 and CNT_W must hold XLEN");
    end

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opb_q, opb_d;   // multiplicand or divisor magnitude
    logic [XLEN-1:0]     mq_q, mq_d;     // multiplier, or dividend shifting into quotient
    logic [2:0]          f3_q, f3_d;
    logic [4:0]          rd_q, rd_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic [4:0]          rd_out_q, rd_out_d;
    logic                done_q, done_d;

    // Start-cycle decode
    logic            a_neg, b_neg, div_zero, div_ovf, res_neg;
    logic [XLEN-1:0] a_abs, b_abs;

    assign a_neg    = rs1_data[XLEN-1] &&
                      (funct3 == F3_MULH || funct3 == F3_MULHSU ||
                       funct3 == F3_DIV  || funct3 == F3_REM);
    assign b_neg    = rs2_data[XLEN-1] &&
                      (funct3 == F3_MULH || funct3 == F3_DIV || funct3 == F3_REM);
    assign div_zero = funct3[2] && (rs2_data == '0);
    assign div_ovf  = (funct3 == F3_DIV || funct3 == F3_REM) &&
                      (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    // Remainder follows the dividend; everything else follows sign(a) ^ sign(b).
    assign res_neg  = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);

    rv32m_sign_fix #(.W(XLEN)) u_abs_a (.data_in(rs1_data), .neg(a_neg), .data_out(a_abs));
    rv32m_sign_fix #(.W(XLEN)) u_abs_b (.data_in(rs2_data), .neg(b_neg), .data_out(b_abs));

    // Iteration datapath
    logic [XLEN:0]   mul_sum, div_shift;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (mq_q[0] ? opb_q : '0)};
    assign div_shift = {acc_q[XLEN-1:0], mq_q[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, opb_q};
    // Remainder stays below the divisor, so the low XLEN bits of the difference suffice.
    assign div_diff  = div_shift[XLEN-1:0] - opb_q;

    // Final sign correction
    logic [2*XLEN-1:0] fix_in, fix_out;

    assign fix_in = f3_q[2] ? {{XLEN{1'b0}}, (f3_q[1] ? acc_q[XLEN-1:0] : mq_q)} : acc_q;

    rv32m_sign_fix #(.W(2*XLEN)) u_fix (.data_in(fix_in), .neg(neg_q), .data_out(fix_out));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        mq_d     = mq_q;
        f3_d     = f3_q;
        rd_d     = rd_q;
        neg_d    = neg_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        done_d   = 1'b0;
        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        f3_d  = funct3;
                        rd_d  = rd_in;
                        cnt_d = '0;
                        if (div_zero || div_ovf) begin
                            // Preload the architectural answer; no iteration, no sign fix.
                            neg_d   = 1'b0;
                            opb_d   = rs2_data;
                            acc_d   = div_zero ? {{XLEN{1'b0}}, rs1_data} : '0;
                            mq_d    = div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
                            state_d = StFinal;
                        end else begin
                            neg_d   = res_neg;
                            acc_d   = '0;
                            opb_d   = funct3[2] ? b_abs : a_abs;
                            mq_d    = funct3[2] ? a_abs : b_abs;
                            state_d = StCalc;
                        end
                    end
                end
                StCalc: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (f3_q[2]) begin
                        acc_d = {{XLEN{1'b0}}, (div_ge ? div_diff : div_shift[XLEN-1:0])};
                        mq_d  = {mq_q[XLEN-2:0], div_ge};
                    end else begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                        mq_d  = mq_q >> 1;
                    end
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_d = StFinal;
                    end
                end
                StFinal: begin
                    result_d = (!f3_q[2] && f3_q != F3_MUL) ? fix_out[2*XLEN-1:XLEN]
                                                            : fix_out[XLEN-1:0];
                    rd_out_d = rd_q;
                    done_d   = 1'b1;
                    state_d  = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            mq_q     <= '0;
            f3_q     <= '0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            mq_q     <= mq_d;
            f3_q     <= f3_d;
            rd_q     <= rd_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            rd_out_q <= rd_out_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = done_q;
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_rv32m_muldiv_unit.sv
// Self-checking bench for rv32m_muldiv_unit: arithmetic reference model plus directed
// literal cases, randomized operations, flush and asynchronous reset.
module tb_rv32m_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;

    rv32m_muldiv_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .flush    (flush),
        .funct3   (funct3),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_in    (rd_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .rd_out   (rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural RV32M result from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_calc(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        logic            ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin up = ua * ub; return up[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                sp = sa / sb; return sp[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                up = ua / ub; return up[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                sp = sa % sb; return sp[31:0];
            end
            default: begin
                if (b == 0) return a;
                up = ua % ub; return up[31:0];
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        return f3[2] && ((b == 0) ||
               (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Transaction-level model: one op in flight, counted down to its completion edge.
    logic        m_busy = 1'b0, m_done = 1'b0;
    int          m_left = 0;
    logic [31:0] m_pend = '0, m_result = '0;
    logic [4:0]  m_pend_rd = '0, m_rdout = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_left   <= 0;
            m_result <= '0;
            m_rdout  <= '0;
        end else begin
            m_done <= 1'b0;
            if (flush) begin
                m_busy <= 1'b0;
            end else if (!m_busy) begin
                if (start) begin
                    m_busy    <= 1'b1;
                    m_left    <= is_special(funct3, rs1_data, rs2_data) ? 1 : 33;
                    m_pend    <= ref_calc(funct3, rs1_data, rs2_data);
                    m_pend_rd <= rd_in;
                end
            end else if (m_left == 1) begin
                m_busy   <= 1'b0;
                m_done   <= 1'b1;
                m_result <= m_pend;
                m_rdout  <= m_pend_rd;
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    always @(negedge clk) begin
        check("model busy", {31'd0, busy}, {31'd0, m_busy});
        check("model done", {31'd0, done}, {31'd0, m_done});
        check("model result", result, m_result);
        check("model rd_out", {27'd0, rd_out}, {27'd0, m_rdout});
    end

    // Issue one op at the current negedge and wait for done; optional junk starts while busy.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat,
                          input bit noise, input string name);
        int n;
        funct3   = f3;
        rs1_data = a;
        rs2_data = b;
        rd_in    = rd;
        start    = 1'b1;
        @(negedge clk);
        n = 1;
        while (!done && n < 60) begin
            start    = noise && ($urandom_range(2) == 0);
            funct3   = 3'($urandom);
            rs1_data = $urandom;
            rs2_data = $urandom;
            rd_in    = 5'($urandom);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({name, " latency"}, 32'(n), 32'(exp_lat));
        check({name, " result"}, result, exp_res);
        check({name, " rd_out"}, {27'd0, rd_out}, {27'd0, rd});
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset rd_out", {27'd0, rd_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 34, 1'b0, "mul 7*-3");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 34, 1'b0, "mulh min*min");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 34, 1'b0, "mulhu");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 34, 1'b0, "mulhsu");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 34, 1'b0, "div -7/2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 34, 1'b0, "rem -7/2");
        run_op(3'd5, 32'd100, 32'd7, 5'd7, 32'd14, 34, 1'b0, "divu 100/7");
        run_op(3'd7, 32'd100, 32'd7, 5'd8, 32'd2, 34, 1'b0, "remu 100/7");
        run_op(3'd4, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF, 2, 1'b0, "div 5/0");
        run_op(3'd6, 32'd5, 32'd0, 5'd11, 32'd5, 2, 1'b0, "rem 5/0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 2, 1'b0, "div ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0, 2, 1'b0, "rem ovf");
        // Back-to-back start in the done cycle, then junk starts during CALC.
        run_op(3'd5, 32'd100, 32'd7, 5'd9, 32'd14, 34, 1'b0, "back-to-back");
        run_op(3'd0, 32'd1234, 32'd5678, 5'd14, 32'd7006652, 34, 1'b1, "mul noisy start");

        // Flush in the tenth CALC cycle: no done, result keeps 7006652.
        funct3 = 3'd3; rs1_data = 32'hFFFF_FFFF; rs2_data = 32'hFFFF_FFFF; rd_in = 5'd20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush busy", {31'd0, busy}, 32'd0);
        begin
            int dones = 0;
            repeat (40) begin
                @(negedge clk);
                if (done) dones++;
            end
            check("flush no done", 32'(dones), 32'd0);
        end
        check("flush result held", result, 32'd7006652);
        check("flush rd held", {27'd0, rd_out}, 32'd14);

        // Flush and start together in IDLE: start dropped.
        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush beats start", {31'd0, busy}, 32'd0);
        @(negedge clk);

        // Asynchronous reset in cycle 20 of an operation.
        funct3 = 3'd4; rs1_data = 32'd1000; rs2_data = 32'd3; rd_in = 5'd21;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async rst busy", {31'd0, busy}, 32'd0);
        check("async rst done", {31'd0, done}, 32'd0);
        check("async rst result", result, 32'd0);
        check("async rst rd_out", {27'd0, rd_out}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized ops with biased special cases and occasional flushes.
        for (int i = 0; i < 150; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            logic [4:0]  rd;
            int          sel;
            f3  = 3'($urandom);
            a   = $urandom;
            b   = $urandom;
            rd  = 5'($urandom);
            sel = $urandom_range(15);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) b = 32'($urandom_range(7));
            if (sel == 3) begin
                funct3 = f3; rs1_data = a; rs2_data = b; rd_in = rd;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat ($urandom_range(1, 30)) @(negedge clk);
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                check("rand flush busy", {31'd0, busy}, 32'd0);
            end else begin
                run_op(f3, a, b, rd, ref_calc(f3, a, b),
                       is_special(f3, a, b) ? 2 : 34, 1'b1, "rand op");
            end
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d",
                 checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
